// File: rtl/seq_mult_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mult_hs                                                   |
// | Purpose  : Iterative shift-add multiplier, signed or unsigned per        |
// |            operation, with valid/ready handshakes on both sides, a held  |
// |            result and optional early termination.                        |
// | Ports    : clk          rising-edge clock                                |
// |            rst          asynchronous active-low reset                    |
// |            in_valid     operands a, b, signed_mode valid                 |
// |            in_ready     operands accepted (IDLE)                         |
// |            signed_mode  1: two's-complement operands, 0: unsigned        |
// |            a, b         multiplicand / multiplier (WIDTH bits)           |
// |            out_valid    product valid and held (DONE)                    |
// |            out_ready    consumer accepts the product                     |
// |            product      2*WIDTH-bit result                               |
// |            busy         high in CALC or DONE                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module seq_mult_hs #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic                 sign_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [CW-1:0]        count_q;
   logic [2*WIDTH-1:0]   product_q;

   logic [2*WIDTH-1:0]   acc_d;
   logic [2*WIDTH-1:0]   mcand_d;
   logic [WIDTH-1:0]     mplier_d;
   logic [CW-1:0]        count_d;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic                 w_calc_last;
   logic [2*WIDTH-1:0]   w_result;

   // Magnitudes are taken as unsigned WIDTH-bit values; the most negative
   // operand maps onto 2^(WIDTH-1), which still fits.
   assign w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

   assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mcand_d  = mcand_q << 1;
   assign mplier_d = mplier_q >> 1;
   assign count_d  = count_q + CW'(1);

   // CALC spends one extra cycle after the last shift-add step to apply the
   // sign and load the result register. The early exit only fires after at
   // least one step, so a zero multiplier still passes through one step.
   assign w_calc_last = (count_q == CW'(WIDTH)) ||
                        (EARLY_EXIT && (count_q != '0) && (mplier_q == '0));

   assign w_result = sign_q ? -acc_q : acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sign_q    <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  sign_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_q    <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, w_a_mag};
                  mplier_q <= w_b_mag;
                  count_q  <= '0;
                  state_q  <= S_CALC;
               end
            end
            S_CALC: begin
               if (w_calc_last) begin
                  product_q <= w_result;
                  state_q   <= S_DONE;
               end else begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_d;
                  mplier_q <= mplier_d;
                  count_q  <= count_d;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign product   = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mult_hs                                                |
// | Purpose  : Directed self-checking bench for seq_mult_hs. Instance 0 is   |
// |            built with EARLY_EXIT=0, instance 1 with EARLY_EXIT=1.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_seq_mult_hs;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    in_valid_s;
   logic [1:0]    in_ready_s;
   logic [1:0]    signed_s;
   logic [1:0]    out_valid_s;
   logic [1:0]    out_ready_s;
   logic [1:0]    busy_s;
   logic [W-1:0]  a_s [2];
   logic [W-1:0]  b_s [2];
   logic [2*W-1:0] p_s [2];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   seq_mult_hs #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid_s[0]),
      .in_ready    (in_ready_s[0]),
      .signed_mode (signed_s[0]),
      .a           (a_s[0]),
      .b           (b_s[0]),
      .out_valid   (out_valid_s[0]),
      .out_ready   (out_ready_s[0]),
      .product     (p_s[0]),
      .busy        (busy_s[0])
   );

   seq_mult_hs #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid_s[1]),
      .in_ready    (in_ready_s[1]),
      .signed_mode (signed_s[1]),
      .a           (a_s[1]),
      .b           (b_s[1]),
      .out_valid   (out_valid_s[1]),
      .out_ready   (out_ready_s[1]),
      .product     (p_s[1]),
      .busy        (busy_s[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Called #1 after a rising edge with the selected instance idle.
   // Returns the number of rising edges from the accept edge to out_valid.
   task automatic start_op(input int d, input logic sm, input logic [W-1:0] av,
                           input logic [W-1:0] bv, output int lat);
      int n;
      chk("in_ready_before_op", {63'd0, in_ready_s[d]}, 64'd1);
      signed_s[d]   = sm;
      a_s[d]        = av;
      b_s[d]        = bv;
      in_valid_s[d] = 1'b1;
      @(posedge clk); #1;
      in_valid_s[d] = 1'b0;
      a_s[d]        = $urandom;
      b_s[d]        = $urandom;
      signed_s[d]   = ~sm;
      chk("busy_after_accept", {63'd0, busy_s[d]}, 64'd1);
      lat = 0;
      n   = 0;
      while (out_valid_s[d] !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         lat++;
         n++;
      end
      if (n >= 100) chk("out_valid_timeout", {63'd0, out_valid_s[d]}, 64'd1);
   endtask

   task automatic finish_op(input int d, input int stall);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
      end
      out_ready_s[d] = 1'b1;
      @(posedge clk); #1;
      out_ready_s[d] = 1'b0;
      chk("in_ready_after_op", {63'd0, in_ready_s[d]}, 64'd1);
   endtask

   task automatic op_chk(input string tag, input int d, input logic sm,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [63:0] expv, input int explat);
      int lat;
      start_op(d, sm, av, bv, lat);
      chk(tag, p_s[d], expv);
      chk({tag, "_latency"}, 64'(lat), 64'(explat));
      finish_op(d, 0);
   endtask

   initial begin
      int            lat;
      int            hb;
      int            d;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;
      logic [W-1:0]  mag;
      logic          rsm;
      logic [63:0]   expv;
      logic          seen;

      rst         = 1'b0;
      in_valid_s  = '0;
      signed_s    = '0;
      out_ready_s = '0;
      a_s[0] = '0; a_s[1] = '0;
      b_s[0] = '0; b_s[1] = '0;

      // Reset state (asynchronous: visible before any clock edge)
      #2;
      chk("reset_out_valid", {63'd0, out_valid_s[0]}, 64'd0);
      chk("reset_product", p_s[0], 64'd0);
      chk("reset_busy", {63'd0, busy_s[0]}, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", {63'd0, in_ready_s[0]}, 64'd1);

      // Main function, EARLY_EXIT=0 (latency WIDTH+1 = 33)
      op_chk("s_m7_x_6",        0, 1'b1, 32'hFFFF_FFF9, 32'd6,        64'hFFFF_FFFF_FFFF_FFD6, 33);
      op_chk("s_min_x_min",     0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
      op_chk("u_8000_sq",       0, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
      op_chk("u_ffff_sq",       0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
      op_chk("s_min_x_max",     0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 33);
      op_chk("u_123_x_456",     0, 1'b0, 32'd123,       32'd456,       64'd56088,               33);
      op_chk("s_m1_x_m1",       0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,                   33);

      // Consumer stall: result held, no new operand accepted
      start_op(0, 1'b0, 32'd1000, 32'd3000, lat);
      chk("stall_first_product", p_s[0], 64'd3000000);
      for (int i = 0; i < 10; i++) begin
         in_valid_s[0] = i[0];
         a_s[0]        = 32'd5;
         b_s[0]        = 32'd5;
         @(posedge clk); #1;
         chk("stall_product", p_s[0], 64'd3000000);
         chk("stall_out_valid", {63'd0, out_valid_s[0]}, 64'd1);
         chk("stall_in_ready", {63'd0, in_ready_s[0]}, 64'd0);
      end
      in_valid_s[0] = 1'b0;
      finish_op(0, 0);
      @(posedge clk); #1;
      chk("stall_no_extra_op", {63'd0, busy_s[0]}, 64'd0);

      // Reset in the middle of CALC aborts the operation
      signed_s[0]   = 1'b1;
      a_s[0]        = 32'hFFFF_FFF9;
      b_s[0]        = 32'd6;
      in_valid_s[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_s[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midreset_out_valid", {63'd0, out_valid_s[0]}, 64'd0);
      chk("midreset_product", p_s[0], 64'd0);
      chk("midreset_busy", {63'd0, busy_s[0]}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset_in_ready", {63'd0, in_ready_s[0]}, 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid_s[0] === 1'b1 || busy_s[0] === 1'b1) seen = 1'b1;
      end
      chk("midreset_no_done", {63'd0, seen}, 64'd0);

      // EARLY_EXIT=1
      op_chk("ee_5_x_3",        1, 1'b0, 32'd5,         32'd3,         64'd15,                  3);
      op_chk("ee_b_zero",       1, 1'b0, 32'h1234_5678, 32'd0,         64'd0,                   2);
      op_chk("ee_b_msb",        1, 1'b0, 32'd1,         32'h8000_0000, 64'h0000_0000_8000_0000, 33);
      op_chk("ee_s_m7_x_6",     1, 1'b1, 32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6, 4);

      // Randomised operands against a reference product, both instances
      for (int i = 0; i < 160; i++) begin
         d   = i % 2;
         ra  = $urandom;
         rb  = $urandom >> ($urandom % 32);
         rsm = 1'($urandom % 2);
         if (rsm && ($urandom % 2 == 1)) rb = -rb;
         if (rsm) expv = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
         else     expv = {32'd0, ra} * {32'd0, rb};
         mag = (rsm && rb[31]) ? -rb : rb;
         hb  = 0;
         for (int k = 0; k < W; k++) if (mag[k]) hb = k + 1;
         start_op(d, rsm, ra, rb, lat);
         chk("rand_product", p_s[d], expv);
         if (d == 0) chk("rand_latency", 64'(lat), 64'd33);
         else        chk("rand_latency_ee", 64'(lat), 64'(((hb < 1) ? 1 : hb) + 1));
         finish_op(d, int'($urandom % 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
